median_axis_out_buffer: RTL and testbench
=========================================

MEDIAN_AXIS_OUT_BUFFER -- requirements
Module: median_axis_out_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, minimum 4).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, statistics counter width.
REQ-004 The block SHALL have port i_clk  in  1  clock, all logic on its rising edge.
REQ-005 The block SHALL have port i_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port s_axis_tdata  in  DATA_WIDTH  median pixel from the filter output.
REQ-007 The block SHALL have ports s_axis_tvalid, s_axis_tuser, s_axis_tlast  in  1 each  beat valid, start-of-frame, end-of-line.
REQ-008 The block SHALL have port m_axis_tdata  out  DATA_WIDTH  buffered pixel.
REQ-009 The block SHALL have ports m_axis_tvalid, m_axis_tuser, m_axis_tlast  out  1 each; port m_axis_tready  in  1.
REQ-010 The block SHALL have port o_overflow  out  1  sticky flag, a beat was lost.
REQ-011 The block SHALL have ports o_frame_cnt, o_drop_cnt  out  CNT_WIDTH each  statistics.

Function
REQ-012 Upstream has no backpressure: every s_axis_tvalid beat is either written or dropped in its cycle.
REQ-013 FIFO entry SHALL be {tuser, tlast, tdata}; order preserved; write and read pointers wrap modulo DEPTH, with an occupancy count 0..DEPTH.
REQ-014 FSM states: WAIT_SOF, PASS, DISCARD; reset state WAIT_SOF.
REQ-015 WAIT_SOF: beats with tuser=0 dropped (not counted as drops); beat with tuser=1 written, next state PASS.
REQ-016 PASS: beats written while not full; tuser=1 beat stays in PASS (new frame).
REQ-017 PASS, beat arrives while full and no read that cycle: beat dropped, o_overflow set, next state DISCARD.
REQ-018 DISCARD: all beats dropped and counted until a tuser=1 beat; that beat is written if not full (next PASS), else dropped (stay DISCARD).
REQ-019 Full with simultaneous read (m_axis_tvalid & m_axis_tready) SHALL accept the write; occupancy unchanged.
REQ-020 Output is first-word-fall-through: m_axis_tvalid=1 whenever occupancy>0; head entry drives m_axis_tdata/tuser/tlast.
REQ-021 Latency: write at edge N -> m_axis_tvalid=1 after edge N when FIFO was empty; no same-cycle combinational bypass.
REQ-022 Read occurs only on m_axis_tvalid & m_axis_tready; m_axis_* stable while tvalid=1 and tready=0.
REQ-023 Write and read in the same cycle with occupancy 0: only the write takes effect (no read, since tvalid=0).
REQ-024 o_frame_cnt increments on each written tuser=1 beat; o_drop_cnt increments on each dropped beat in PASS/DISCARD; both saturate at all-ones.

Reset
REQ-025 Asserting i_aresetn low at any time SHALL immediately clear pointers, occupancy, o_overflow, counters and return FSM to WAIT_SOF; buffered beats are discarded.
REQ-026 During reset m_axis_tvalid, m_axis_tuser, m_axis_tlast SHALL be 0; m_axis_tdata 0.
REQ-027 o_overflow SHALL clear only by reset.

Configuration
REQ-028 Macro MEDIAN_OUT_BUF_STATS_EN defined: o_frame_cnt and o_drop_cnt behave per REQ-024.
REQ-029 Macro undefined: counter logic not synthesised, o_frame_cnt and o_drop_cnt tied to 0; ports remain; all other behaviour identical.

Verification
REQ-030 Reset release, beats 0x11(tuser=0),0x22(tuser=1),0x33, tready=1 -> output 0x22(tuser=1),0x33; 0x11 never appears; o_drop_cnt=0.
REQ-031 DEPTH=16, tready=0, 20 beats starting with tuser=1 -> 16 held, o_overflow=1, o_drop_cnt=4 (macro on), state DISCARD.
REQ-032 After REQ-031, tready=1, new tuser=1 beat 0xA5 after FIFO drains one entry -> 16 old beats then 0xA5(tuser=1); o_frame_cnt=2.
REQ-033 Full FIFO, tready=1 and tvalid=1 each cycle for 50 cycles -> no drops, occupancy stays 16, output order matches input.
REQ-034 i_aresetn low mid-frame with 7 entries buffered -> m_axis_tvalid=0 immediately, counters 0; after release next beat with tuser=0 is dropped.
REQ-035 Build without MEDIAN_OUT_BUF_STATS_EN, repeat REQ-031 -> o_overflow=1, o_frame_cnt=0, o_drop_cnt=0.

Source files
------------

// File: rtl/median_axis_out_buffer.sv
// Output FIFO for the median filter's AXI-Stream: first-word-fall-through with frame-aware drop.
// Optional statistics counters are built only when MEDIAN_OUT_BUF_STATS_EN is defined.
module median_axis_out_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_overflow,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [1:0] WAIT_SOF = 2'd0;
  localparam logic [1:0] PASS     = 2'd1;
  localparam logic [1:0] DISCARD  = 2'd2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [1:0]    state_reg, state_next;
  logic          overflow_reg;
  logic          full, rd_en, can_write;
  logic          wr_en, drop_cnt_en, frame_en, set_ovf;
  logic [EW-1:0] head;

  assign full      = (count_reg == FULL_CNT);
  assign rd_en     = m_axis_tvalid & m_axis_tready;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_write = ~full | rd_en;

  always_comb begin
    wr_en       = 1'b0;
    drop_cnt_en = 1'b0;
    frame_en    = 1'b0;
    set_ovf     = 1'b0;
    state_next  = state_reg;
    if (s_axis_tvalid) begin
      case (state_reg)
        WAIT_SOF: begin
          if (s_axis_tuser && can_write) begin
            wr_en      = 1'b1;
            frame_en   = 1'b1;
            state_next = PASS;
          end
        end
        PASS: begin
          if (can_write) begin
            wr_en    = 1'b1;
            frame_en = s_axis_tuser;
          end else begin
            drop_cnt_en = 1'b1;
            set_ovf     = 1'b1;
            state_next  = DISCARD;
          end
        end
        DISCARD: begin
          if (s_axis_tuser && can_write) begin
            wr_en      = 1'b1;
            frame_en   = 1'b1;
            state_next = PASS;
          end else begin
            drop_cnt_en = 1'b1;
          end
        end
        default: state_next = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= WAIT_SOF;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (set_ovf) overflow_reg <= 1'b1;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Outputs are gated by valid so reset and empty present all-zero beats.
  assign head          = mem[rd_ptr_reg];
  assign m_axis_tvalid = (count_reg != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head[DATA_WIDTH];
  assign m_axis_tuser  = m_axis_tvalid & head[DATA_WIDTH+1];
  assign o_overflow    = overflow_reg;

`ifdef MEDIAN_OUT_BUF_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_reg, drop_cnt_reg;

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      if (frame_en && (frame_cnt_reg != '1)) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (drop_cnt_en && (drop_cnt_reg != '1)) drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign o_frame_cnt = frame_cnt_reg;
  assign o_drop_cnt  = drop_cnt_reg;
`else
  logic unused_stats;
  assign unused_stats = frame_en ^ drop_cnt_en;
  assign o_frame_cnt  = '0;
  assign o_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_median_axis_out_buffer.sv
// Directed bench for median_axis_out_buffer (DEPTH=16); counter expectations follow MEDIAN_OUT_BUF_STATS_EN.
module tb_median_axis_out_buffer;
`ifdef MEDIAN_OUT_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_aresetn = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        o_overflow;
  logic [15:0] o_frame_cnt, o_drop_cnt;

  int checks = 0;
  int errors = 0;

  median_axis_out_buffer #(.DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_aresetn(i_aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .o_overflow(o_overflow),
    .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one input beat for one clock, then settle 1 ns after the edge.
  task automatic step(input logic v, input logic u, input logic l, input logic [7:0] d);
    s_axis_tvalid = v;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tdata  = d;
    @(posedge i_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic head(input string tag, input logic [7:0] d, input logic u);
    check({tag, "_valid"}, {31'd0, m_axis_tvalid}, 32'd1);
    check({tag, "_data"}, {24'd0, m_axis_tdata}, {24'd0, d});
    check({tag, "_user"}, {31'd0, m_axis_tuser}, {31'd0, u});
  endtask

  task automatic do_reset();
    i_aresetn = 1'b0;
    @(posedge i_clk);
    #1;
    i_aresetn = 1'b1;
  endtask

  initial begin
    // Reset state
    @(posedge i_clk);
    #1;
    check("rst_valid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_data", {24'd0, m_axis_tdata}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    check("rst_frame", {16'd0, o_frame_cnt}, 32'd0);
    i_aresetn = 1'b1;

    // Pre-SOF beat dropped silently; SOF and following beat pass in order
    m_axis_tready = 1'b1;
    step(1, 0, 0, 8'h11);
    check("presof_valid", {31'd0, m_axis_tvalid}, 32'd0);
    step(1, 1, 0, 8'h22);
    head("sof", 8'h22, 1'b1);
    step(1, 0, 1, 8'h33);
    head("beat33", 8'h33, 1'b0);
    check("beat33_last", {31'd0, m_axis_tlast}, 32'd1);
    step(0, 0, 0, 8'h00);
    check("empty_valid", {31'd0, m_axis_tvalid}, 32'd0);
    check("presof_drop", {16'd0, o_drop_cnt}, 32'd0);
    check("first_frame", {16'd0, o_frame_cnt}, STATS ? 32'd1 : 32'd0);

    // Overflow: 20 beats into a stalled 16-entry FIFO
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) step(1, (i == 0), 0, 8'h40 + 8'(i));
    head("ovf_head", 8'h40, 1'b1);
    check("ovf_flag", {31'd0, o_overflow}, 32'd1);
    check("ovf_drop", {16'd0, o_drop_cnt}, STATS ? 32'd4 : 32'd0);
    check("ovf_frame", {16'd0, o_frame_cnt}, STATS ? 32'd1 : 32'd0);

    // Recovery: a non-SOF beat is still discarded, next SOF is accepted
    m_axis_tready = 1'b1;
    step(0, 0, 0, 8'h00);
    head("rec1", 8'h41, 1'b0);
    step(1, 0, 0, 8'h77);
    head("rec2", 8'h42, 1'b0);
    step(1, 1, 0, 8'hA5);
    for (int i = 3; i < 16; i++) begin
      check("rec_data", {24'd0, m_axis_tdata}, {24'd0, 8'h40 + 8'(i)});
      step(0, 0, 0, 8'h00);
    end
    head("rec_sof", 8'hA5, 1'b1);
    step(0, 0, 0, 8'h00);
    check("rec_empty", {31'd0, m_axis_tvalid}, 32'd0);
    check("rec_frame", {16'd0, o_frame_cnt}, STATS ? 32'd2 : 32'd0);
    check("rec_drop", {16'd0, o_drop_cnt}, STATS ? 32'd5 : 32'd0);
    check("rec_ovf_sticky", {31'd0, o_overflow}, 32'd1);

    // Full FIFO with simultaneous read and write for 50 cycles
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) step(1, (i == 0), 0, 8'h80 + 8'(i));
    m_axis_tready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check("stream_data", {24'd0, m_axis_tdata}, {24'd0, 8'h80 + 8'(i)});
      step(1, 0, 0, 8'h90 + 8'(i));
    end
    for (int j = 0; j < 16; j++) begin
      check("drain_valid", {31'd0, m_axis_tvalid}, 32'd1);
      check("drain_data", {24'd0, m_axis_tdata}, {24'd0, 8'h80 + 8'(50 + j)});
      step(0, 0, 0, 8'h00);
    end
    check("drain_empty", {31'd0, m_axis_tvalid}, 32'd0);
    check("stream_drop", {16'd0, o_drop_cnt}, STATS ? 32'd5 : 32'd0);
    check("stream_frame", {16'd0, o_frame_cnt}, STATS ? 32'd3 : 32'd0);

    // Asynchronous reset mid-frame with 7 entries held
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) step(1, (i == 0), 0, 8'hC0 + 8'(i));
    head("pre_rst", 8'hC0, 1'b1);
    #2;
    i_aresetn = 1'b0;
    #1;
    check("arst_valid", {31'd0, m_axis_tvalid}, 32'd0);
    check("arst_data", {24'd0, m_axis_tdata}, 32'd0);
    check("arst_user", {31'd0, m_axis_tuser}, 32'd0);
    check("arst_ovf", {31'd0, o_overflow}, 32'd0);
    check("arst_frame", {16'd0, o_frame_cnt}, 32'd0);
    check("arst_drop", {16'd0, o_drop_cnt}, 32'd0);
    @(posedge i_clk);
    #1;
    i_aresetn = 1'b1;
    m_axis_tready = 1'b1;
    step(1, 0, 0, 8'h55);
    check("post_rst_drop", {31'd0, m_axis_tvalid}, 32'd0);
    step(1, 1, 1, 8'h66);
    head("post_rst_sof", 8'h66, 1'b1);
    check("post_rst_last", {31'd0, m_axis_tlast}, 32'd1);
    step(0, 0, 0, 8'h00);
    check("post_rst_empty", {31'd0, m_axis_tvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
